// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory with a fixed read latency.
// Build with MEM_ARB_ROUND_ROBIN_EN defined for round-robin tie-breaks; default is fixed priority to port 0.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_cnt;
    logic              r_winner;
    logic              r_last_winner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the port that did not win last time goes first.
    always_comb begin
        if (req0 && req1) begin
            w_winner = ~r_last_winner;
        end else begin
            w_winner = ~req0;
        end
    end
`else
    logic w_unused_last_winner;
    assign w_unused_last_winner = r_last_winner;
    assign w_winner             = ~req0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req0 || req1) w_state_next = ISSUE;
            ISSUE:   w_state_next = r_we ? DONE : WAIT;
            WAIT:    if (r_cnt == 2'd0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= 2'd0;
            r_winner      <= 1'b0;
            r_last_winner <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    // The command is captured only here; later req changes are ignored.
                    if (req0 || req1) begin
                        r_winner      <= w_winner;
                        r_last_winner <= w_winner;
                        r_we          <= w_winner ? we1 : we0;
                        r_addr        <= w_winner ? addr1 : addr0;
                        r_wdata       <= w_winner ? wdata1 : wdata0;
                    end
                end
                ISSUE: r_cnt <= CNT_LOAD;
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_rdata <= mem_rdata;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt0      = (r_state == ISSUE) && !r_winner;
    assign gnt1      = (r_state == ISSUE) &&  r_winner;
    assign done0     = (r_state == DONE)  && !r_winner;
    assign done1     = (r_state == DONE)  &&  r_winner;
    assign mem_en    = (r_state == ISSUE);
    assign mem_we    = (r_state == ISSUE) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3), each with its own memory model,
// checked cycle by cycle against a timestamp-based transaction model.
module tb_mem_port_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int RL0 = 1;
    localparam int RL1 = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    reset, req0, we0, req1, we1;
    logic [1:0]    gnt0, gnt1, done0, done1, mem_en, mem_we, busy;
    logic [AW-1:0] addr0 [2];
    logic [AW-1:0] addr1 [2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] wdata0 [2];
    logic [DW-1:0] wdata1 [2];
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];

    int            n_tests = 0;
    int            n_fail  = 0;
    int            mlw [2];
    logic [DW-1:0] mrd [2];
    logic [DW-1:0] mm [2][4096];
    bit            mwr [2][4096];
    cmd_t          q0 [$];
    cmd_t          q1 [$];
    int            gq [$];

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {8'h5A, a, ~a};
    endfunction

    function automatic int rl(input int inst);
        return (inst == 0) ? RL0 : RL1;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? RL0 : RL1;
        logic [DW-1:0] mem [4096];
        bit            written [4096];
        bit [DW-1:0]   pd [4];
        bit            pv [4];
        bit [DW-1:0]   junk;

        // Memory returns data exactly LAT cycles after the access edge, random junk otherwise.
        always @(posedge clk) begin
            junk <= $urandom;
            if (mem_en[gi] && mem_we[gi]) begin
                mem[mem_addr[gi]]     <= mem_wdata[gi];
                written[mem_addr[gi]] <= 1'b1;
            end
            pv[0] <= mem_en[gi] && !mem_we[gi];
            pd[0] <= written[mem_addr[gi]] ? mem[mem_addr[gi]] : pattern(mem_addr[gi]);
            for (int k = 1; k < 4; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
        assign mem_rdata[gi] = pv[LAT-1] ? pd[LAT-1] : junk;

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)) u_dut (
            .clk(clk), .reset(reset[gi]),
            .req0(req0[gi]), .we0(we0[gi]), .addr0(addr0[gi]), .wdata0(wdata0[gi]),
            .gnt0(gnt0[gi]), .done0(done0[gi]),
            .req1(req1[gi]), .we1(we1[gi]), .addr1(addr1[gi]), .wdata1(wdata1[gi]),
            .gnt1(gnt1[gi]), .done1(done1[gi]),
            .rdata(rdata[gi]), .mem_en(mem_en[gi]), .mem_we(mem_we[gi]),
            .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]),
            .busy(busy[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input int inst, input logic [AW-1:0] a);
        return mwr[inst][a] ? mm[inst][a] : pattern(a);
    endfunction

    task automatic add_cmd(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.data = d;
        if (port == 0) q0.push_back(c);
        else q1.push_back(c);
    endtask

    task automatic check_idle_zero(input int inst, input string pfx);
        check_eq({pfx, "_gnt0"},  gnt0[inst],      0);
        check_eq({pfx, "_gnt1"},  gnt1[inst],      0);
        check_eq({pfx, "_done0"}, done0[inst],     0);
        check_eq({pfx, "_done1"}, done1[inst],     0);
        check_eq({pfx, "_men"},   mem_en[inst],    0);
        check_eq({pfx, "_mwe"},   mem_we[inst],    0);
        check_eq({pfx, "_maddr"}, mem_addr[inst],  0);
        check_eq({pfx, "_mwdat"}, mem_wdata[inst], 0);
        check_eq({pfx, "_rdata"}, rdata[inst],     0);
        check_eq({pfx, "_busy"},  busy[inst],      0);
    endtask

    // Entered and left just after a rising edge.
    task automatic do_reset(input int inst);
        reset[inst] = 1'b1;
        req0[inst]  = 1'b0;
        req1[inst]  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_zero(inst, "rst");
        @(posedge clk); #1;
        reset[inst] = 1'b0;
        mlw[inst]   = 1;
        mrd[inst]   = '0;
    endtask

    // Drives the queued commands of both ports and checks every cycle against the transaction model:
    // acceptance at cycle A gives gnt at A+1, done at A+2 (write) or A+2+latency (read).
    task automatic run_batch(input int inst, input int dly0, input int dly1);
        int            c = 0, free = 0, t_gnt = -10, t_done = -10, win = 0, i0 = 0, i1 = 0;
        bit            r0, r1;
        cmd_t          cur;
        logic [DW-1:0] exp_rd = '0;
        cur.we = 1'b0; cur.addr = '0; cur.data = '0;
        forever begin
            r0 = (c >= dly0) && (i0 < q0.size());
            r1 = (c >= dly1) && (i1 < q1.size());
            req0[inst] = r0;
            req1[inst] = r1;
            if (r0) begin we0[inst] = q0[i0].we; addr0[inst] = q0[i0].addr; wdata0[inst] = q0[i0].data; end
            if (r1) begin we1[inst] = q1[i1].we; addr1[inst] = q1[i1].addr; wdata1[inst] = q1[i1].data; end
            if (c >= free && (r0 || r1)) begin
                if (r0 && r1) win = RR ? (1 - mlw[inst]) : 0;
                else          win = r0 ? 0 : 1;
                mlw[inst] = win;
                cur    = (win == 1) ? q1[i1] : q0[i0];
                t_gnt  = c + 1;
                t_done = cur.we ? c + 2 : c + 2 + rl(inst);
                free   = t_done + 1;
                if (cur.we) begin
                    mm[inst][cur.addr]  = cur.data;
                    mwr[inst][cur.addr] = 1'b1;
                end else begin
                    exp_rd = model_rd(inst, cur.addr);
                end
            end
            @(negedge clk);
            if (c == t_done && !cur.we) mrd[inst] = exp_rd;
            check_eq("gnt0",  gnt0[inst],  (c == t_gnt)  && win == 0);
            check_eq("gnt1",  gnt1[inst],  (c == t_gnt)  && win == 1);
            check_eq("done0", done0[inst], (c == t_done) && win == 0);
            check_eq("done1", done1[inst], (c == t_done) && win == 1);
            check_eq("men",   mem_en[inst], c == t_gnt);
            check_eq("mwe",   mem_we[inst], (c == t_gnt) && cur.we);
            check_eq("busy",  busy[inst],  (c >= t_gnt) && (c <= t_done));
            check_eq("rdata", rdata[inst], mrd[inst]);
            if (c == t_gnt) begin
                check_eq("maddr", mem_addr[inst], cur.addr);
                if (cur.we) check_eq("mwdata", mem_wdata[inst], cur.data);
            end
            if (gnt0[inst]) begin gq.push_back(0); i0++; end
            if (gnt1[inst]) begin gq.push_back(1); i1++; end
            if (c == t_done)
                $display("[TB] inst%0d port%0d %s addr=%03h data=%08h gnt@%0d done@%0d",
                         inst, win, cur.we ? "WR" : "RD", cur.addr,
                         cur.we ? cur.data : exp_rd, t_gnt, t_done);
            if (i0 >= q0.size() && i1 >= q1.size() && c > t_done) break;
            if (c > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout: batch on inst%0d not finished after %0d cycles", inst, c);
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        req0[inst] = 1'b0;
        req1[inst] = 1'b0;
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        reset = '1; req0 = '0; req1 = '0; we0 = '0; we1 = '0;
        for (int i = 0; i < 2; i++) begin
            addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
            mlw[i] = 1; mrd[i] = '0;
        end
        do_reset(0);
        do_reset(1);

        // Read of preloaded word at latency 1.
        add_cmd(0, 1'b0, 12'h010, 32'h0);
        run_batch(0, 0, 0);
        check_eq("t1_rdata", rdata[0], 32'hDEADBEEF);

        // Port 1 write, then port 0 reads it back.
        add_cmd(1, 1'b1, 12'h020, 32'h12345678);
        run_batch(0, 0, 0);
        add_cmd(0, 1'b0, 12'h020, 32'h0);
        run_batch(0, 0, 0);
        check_eq("t2_rdata", rdata[0], 32'h12345678);

        // Continuous contention from reset.
        do_reset(0);
        gq.delete();
        for (int k = 0; k < 3; k++) begin
            add_cmd(0, 1'b0, 12'(k + 1), 32'h0);
            add_cmd(1, 1'b0, 12'(k + 8), 32'h0);
        end
        run_batch(0, 0, 0);
        check_eq("t3_count", gq.size(), 6);
        for (int k = 0; k < 3 && k < gq.size(); k++)
            check_eq("t3_order", gq[k], RR ? (k % 2) : 0);

        // Latency 3 read.
        add_cmd(0, 1'b0, 12'h0AB, 32'h0);
        run_batch(1, 0, 0);
        check_eq("t4_rdata", rdata[1], pattern(12'h0AB));

        // Reset while waiting for read data.
        req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 12'h033;
        @(posedge clk); #1;
        req0[1] = 1'b0;
        @(posedge clk); #1;
        reset[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_zero(1, "t5");
        @(posedge clk); #1;
        reset[1] = 1'b0;
        mlw[1] = 1;
        mrd[1] = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("t5_done0", done0[1], 0);
            check_eq("t5_done1", done1[1], 0);
            check_eq("t5_men",   mem_en[1], 0);
            check_eq("t5_busy",  busy[1],  0);
            @(posedge clk); #1;
        end
        add_cmd(1, 1'b0, 12'h033, 32'h0);
        run_batch(1, 0, 0);

        // Port 1 arrives during port 0's wait.
        add_cmd(0, 1'b0, 12'h011, 32'h0);
        add_cmd(1, 1'b0, 12'h012, 32'h0);
        run_batch(1, 0, 3);

        // Random mixes of reads, writes, contention and late arrivals.
        for (int inst = 0; inst < 2; inst++) begin
            for (int b = 0; b < 12; b++) begin
                n0 = $urandom_range(0, 2);
                n1 = $urandom_range(0, 2);
                if (n0 + n1 == 0) n0 = 1;
                for (int k = 0; k < n0; k++)
                    add_cmd(0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), $urandom);
                for (int k = 0; k < n1; k++)
                    add_cmd(1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), $urandom);
                run_batch(inst, $urandom_range(0, 4), $urandom_range(0, 4));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters: port 0 (multicycle CPU fetch/load/store path) and port 1 (program loader / debug master).
- Accepts one transaction at a time, drives the memory for one cycle, waits the fixed memory read latency, and returns a done pulse with read data to the winner.
- Sits between the multicycle core's memory address mux and the memory macro.

Parameters:
- ADDR_W, 12, word-address width on both ports and the memory side.
- DATA_W, 32, data width.
- READ_LATENCY, 1, cycles from the mem_en edge until mem_rdata is valid; legal range 1..4.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held with its command until gnt0.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- gnt0  output  1  one-cycle pulse: port 0 command accepted.
- done0  output  1  one-cycle pulse: port 0 transaction complete.
- req1, we1, addr1, wdata1, gnt1, done1  as port 0, for port 1.
- rdata  output  DATA_W  read data; valid while done0 or done1 is high after a read.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Outputs are registered or decoded from registered state only. No combinational path from req* to any output.
- Reset (sampled at the clock edge): state = IDLE, latency counter = 0, last_winner = 1, rdata = 0. All outputs are 0.
- Reset mid-transaction abandons the command. No done pulse is issued and the memory is not re-accessed.
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - If req0 or req1 is high, select a winner and latch winner, we, addr and wdata. Then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched command.
  - gnt of the winner = 1.
  - For a write, go to DONE.
  - For a read, load the counter with READ_LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata into rdata and go to DONE.
- DONE (one cycle):
  - done of the winner = 1.
  - rdata holds the captured value and is held until the next read capture. For writes it is unchanged.
  - Next state is IDLE.
- mem_en, mem_we and gnt* are 0 outside ISSUE. mem_addr and mem_wdata hold the latched values.
- Latency, with a request first seen in IDLE at cycle T:
  - gnt and mem_en at T+1.
  - Read done at T+2+READ_LATENCY.
  - Write done at T+2.
  - The next acceptance happens no earlier than the cycle after DONE.
- Requests arriving while busy are ignored until IDLE; the requester keeps req high.
- A req that drops before gnt is legal and is simply not served. The command is captured only at the IDLE->ISSUE edge.
- last_winner is updated on every IDLE->ISSUE transition.
- Only one of gnt0/gnt1 and only one of done0/done1 is ever high in a cycle.
- rdata is zero-width-extended as needed; no arithmetic on data.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when req0 and req1 are both high in IDLE, the port that is not last_winner wins. Ports alternate under continuous contention.
- Undefined: fixed priority, port 0 always wins a tie and port 1 may starve. last_winner is still maintained but unused.
- A single request always wins in both builds.

Test Plan:
- Reset, then port 0 read of addr 0x010 holding 0xDEADBEEF, READ_LATENCY=1. Required response: gnt0 at T+1 with mem_en=1, mem_we=0, mem_addr=0x010; done0 at T+3 with rdata=0xDEADBEEF; busy low at T+4.
- Port 1 write of addr 0x020 with data 0x12345678. Required response: gnt1 and mem_en=mem_we=1 at T+1 with mem_wdata=0x12345678; done1 at T+2. A port 0 read of 0x020 afterwards returns 0x12345678.
- req0 and req1 high together for 3 transactions. Required response:
  - Round-robin build: grant order 0,1,0.
  - Fixed-priority build: grant order 0,0,0.
- READ_LATENCY=3 read. Required response: done at T+5; rdata equals the mem_rdata value present at T+4, not at T+2 or T+3.
- Reset asserted in WAIT. Required response: next cycle all outputs 0 and busy=0; no done pulse follows; a new request is served normally.
- req1 raised during port 0's WAIT. Required response: no gnt1 until port 0's DONE completes; gnt1 in the second cycle after DONE.
